// File: rtl/lab2_regfile_sequencer.sv
// lab2_regfile_sequencer: multi-cycle IDLE/READ/EXEC/WRITE control stage driving an external 4 x W register file.
// Latency: 4 cycles per instruction; rf_we and done assert in the 3rd cycle after the accept edge.
// Backpressure: instr_ready is high only in IDLE; instr_valid seen in other states is ignored and must be held.
// Build option: define LAB2_SEQ_CMP_EN to make op 111 a flag-only CMP; when undefined op 111 is a NOP.
module lab2_regfile_sequencer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [8+W:0] instr,
   input  logic [W-1:0] rf_out1,
   input  logic [W-1:0] rf_out2,
   output logic         rf_we,
   output logic [W-1:0] rf_in,
   output logic [1:0]   rf_sel1,
   output logic [1:0]   rf_sel2,
   output logic [1:0]   rf_sel_dest,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_n,
   output logic         busy,
   output logic         done
);

   localparam int IW = 9 + W;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_X7  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   // Latched instruction and its decoded fields
   logic [IW-1:0] instr_q;
   logic [2:0]    op;
   logic [1:0]    dest;
   logic [1:0]    src1;
   logic [1:0]    src2;
   logic [W-1:0]  imm;

   // Operand and result registers
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  r_q;

   // ALU combinational results
   logic [W:0]    sum_ext;
   logic [W:0]    dif_ext;
   logic [W-1:0]  alu_r;
   logic          alu_c;
   logic          flag_upd;
   logic          op_writes;

   assign op   = instr_q[IW-1 -: 3];
   assign dest = instr_q[IW-4 -: 2];
   assign src1 = instr_q[IW-6 -: 2];
   assign src2 = instr_q[IW-8 -: 2];
   assign imm  = instr_q[W-1:0];

   // Selects come straight from the latched instruction so they are stable in every state.
   assign rf_sel1     = src1;
   assign rf_sel2     = src2;
   assign rf_sel_dest = dest;
   assign rf_in       = r_q;

   // Op 111 never writes the register file in either build.
   assign op_writes = (op != OP_X7);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and state-decoded control outputs; rf_we decoded from state so a reset can never leak a write.
   always_comb begin
      next_state  = state;
      instr_ready = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      rf_we       = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) begin
               next_state = READ;
            end
         end
         READ: begin
            next_state = EXEC;
         end
         EXEC: begin
            next_state = WRITE;
         end
         WRITE: begin
            done       = 1'b1;
            rf_we      = op_writes;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Latch the instruction on the accept edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
      end else if (state == IDLE && instr_valid) begin
         instr_q <= instr;
      end
   end

   // Capture both read ports at the end of READ; later writes to the same register cannot disturb them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (state == READ) begin
         a_q <= rf_out1;
         b_q <= rf_out2;
      end
   end

   // ALU: result, carry and whether this op touches the flags
   always_comb begin
      sum_ext  = {1'b0, a_q} + {1'b0, b_q};
      dif_ext  = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
      alu_r    = '0;
      alu_c    = 1'b0;
      flag_upd = 1'b0;
      case (op)
         OP_ADD: begin
            alu_r    = sum_ext[W-1:0];
            alu_c    = sum_ext[W];
            flag_upd = 1'b1;
         end
         OP_SUB: begin
            alu_r    = dif_ext[W-1:0];
            alu_c    = dif_ext[W];
            flag_upd = 1'b1;
         end
         OP_AND: begin
            alu_r    = a_q & b_q;
            flag_upd = 1'b1;
         end
         OP_OR: begin
            alu_r    = a_q | b_q;
            flag_upd = 1'b1;
         end
         OP_XOR: begin
            alu_r    = a_q ^ b_q;
            flag_upd = 1'b1;
         end
         OP_LDI: begin
            alu_r = imm;
         end
         OP_MOV: begin
            alu_r = a_q;
         end
         default: begin
`ifdef LAB2_SEQ_CMP_EN
            // CMP: subtract purely for the flags
            alu_r    = dif_ext[W-1:0];
            alu_c    = dif_ext[W];
            flag_upd = 1'b1;
`else
            // NOP: nothing computed, flags untouched
            alu_r    = '0;
`endif
         end
      endcase
   end

   // Register the result at the end of EXEC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (state == EXEC) begin
         r_q <= alu_r;
      end
   end

   // Flags update at the end of EXEC so they are visible from WRITE onward
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_n <= 1'b0;
      end else if (state == EXEC && flag_upd) begin
         flag_z <= (alu_r == '0);
         flag_c <= alu_c;
         flag_n <= alu_r[W-1];
      end
   end

endmodule

// File: tb/tb_lab2_regfile_sequencer.sv
// Bench for lab2_regfile_sequencer: register-file model, scoreboard queue, directed then random instructions.
// Expected results come from an integer-arithmetic reference of the instruction set.
// A negedge monitor pops one expectation per done pulse and compares write, flags and timing.
`timescale 1ns/1ps
module tb_lab2_regfile_sequencer;

   localparam int W = 3;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [8+W:0] instr = '0;
   logic [W-1:0] rf_out1;
   logic [W-1:0] rf_out2;
   logic         rf_we;
   logic [W-1:0] rf_in;
   logic [1:0]   rf_sel1;
   logic [1:0]   rf_sel2;
   logic [1:0]   rf_sel_dest;
   logic         flag_z;
   logic         flag_c;
   logic         flag_n;
   logic         busy;
   logic         done;

   lab2_regfile_sequencer #(.W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .rf_out1     (rf_out1),
      .rf_out2     (rf_out2),
      .rf_we       (rf_we),
      .rf_in       (rf_in),
      .rf_sel1     (rf_sel1),
      .rf_sel2     (rf_sel2),
      .rf_sel_dest (rf_sel_dest),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .flag_n      (flag_n),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Register file model: two combinational reads, one clocked write, not touched by reset
   logic         rf_clr = 1'b1;
   logic [W-1:0] rf [4];
   assign rf_out1 = rf[rf_sel1];
   assign rf_out2 = rf[rf_sel2];
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else if (rf_we) begin
         rf[rf_sel_dest] <= rf_in;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference architectural state
   int regs [4];
   int mz = 0;
   int mc = 0;
   int mn = 0;

   typedef struct {
      int we;
      int dest;
      int data;
      int z;
      int c;
      int n;
      int cyc;
   } exp_t;

   exp_t q [$];

   // Execute one instruction on the reference state and report what WRITE should show
   task automatic model(input int op, input int dest, input int s1, input int s2, input int imm,
                        output exp_t e);
      int a, b, res, c, upd, s;
      a = regs[s1];
      b = regs[s2];
      res = 0; c = 0; upd = 0;
      e.we = 1;
      case (op)
         0: begin s = a + b; res = s % M; c = (s >= M) ? 1 : 0; upd = 1; end
         1: begin res = (a - b + M) % M; c = (a >= b) ? 1 : 0; upd = 1; end
         2: begin res = a & b; upd = 1; end
         3: begin res = a | b; upd = 1; end
         4: begin res = a ^ b; upd = 1; end
         5: res = imm % M;
         6: res = a;
         default: begin
            e.we = 0;
`ifdef LAB2_SEQ_CMP_EN
            res = (a - b + M) % M; c = (a >= b) ? 1 : 0; upd = 1;
`endif
         end
      endcase
      if (upd != 0) begin
         mz = (res == 0) ? 1 : 0;
         mc = c;
         mn = (res >= M / 2) ? 1 : 0;
      end
      if (e.we != 0) regs[dest] = res;
      e.dest = dest;
      e.data = res;
      e.z = mz;
      e.c = mc;
      e.n = mn;
      e.cyc = 0;
   endtask

   // Present an instruction and wait (bounded) for the accept edge; optionally leave valid asserted
   task automatic issue(input int op, input int dest, input int s1, input int s2, input int imm,
                        input bit keep_valid, input bit track, output int acc_cyc);
      int n;
      exp_t e;
      instr = {3'(op), 2'(dest), 2'(s1), 2'(s2), W'(imm)};
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         check("accept_timeout", 0, 1);
         instr_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (track) begin
         model(op, dest, s1, s2, imm, e);
         e.cyc = cyc + 2;
         q.push_back(e);
      end
      if (!keep_valid) instr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", q.size(), 0);
   endtask

   // Monitor: one expectation per done pulse; writes only ever appear together with done
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         check("we_without_done", int'(rf_we & ~done), 0);
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               check("write_cycle", cyc, e.cyc);
               check("rf_we", int'(rf_we), e.we);
               if (e.we != 0) begin
                  check("rf_sel_dest", int'(rf_sel_dest), e.dest);
                  check("rf_in", int'(rf_in), e.data);
               end
               check("flag_z", int'(flag_z), e.z);
               check("flag_c", int'(flag_c), e.c);
               check("flag_n", int'(flag_n), e.n);
            end
         end
      end
   end

   initial begin
      int a0, a1, a2, a3, a4, a5, a6, a7, dummy;
      for (int i = 0; i < 4; i++) regs[i] = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_instr_ready", int'(instr_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rf_we", int'(rf_we), 0);
      check("rst_flags", int'({flag_z, flag_c, flag_n}), 0);
      rf_clr = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // Directed program, instr_valid held high throughout
      issue(5, 1, 0, 0, 5, 1'b1, 1'b1, a0);   // LDI r1,5
      issue(5, 2, 0, 0, 3, 1'b1, 1'b1, a1);   // LDI r2,3
      issue(0, 3, 1, 2, 0, 1'b1, 1'b1, a2);   // ADD r3,r1,r2
      issue(1, 0, 2, 1, 0, 1'b1, 1'b1, a3);   // SUB r0,r2,r1
      issue(1, 0, 1, 2, 0, 1'b1, 1'b1, a4);   // SUB r0,r1,r2
      issue(6, 2, 1, 0, 0, 1'b1, 1'b1, a5);   // MOV r2,r1
      issue(6, 2, 1, 0, 0, 1'b1, 1'b1, a6);   // same MOV still held: re-accepted only in IDLE
      issue(7, 0, 1, 1, 0, 1'b0, 1'b1, a7);   // op 111 r1,r1
      check("spacing_ldi", a1 - a0, 4);
      check("spacing_add", a2 - a1, 4);
      check("spacing_sub", a4 - a3, 4);
      check("spacing_held_mov", a6 - a5, 4);
      check("spacing_op7", a7 - a6, 4);
      drain();

      // Architectural results of the directed program
      check("r0_after_prog", int'(rf[0]), 2);
      check("r1_after_prog", int'(rf[1]), 5);
      check("r2_after_mov", int'(rf[2]), 5);
      check("r3_after_add", int'(rf[3]), 0);
`ifdef LAB2_SEQ_CMP_EN
      check("cmp_flags", int'({flag_z, flag_c, flag_n}), 3'b110);
`else
      check("nop_flags", int'({flag_z, flag_c, flag_n}), 3'b010);
`endif

      // Reset in the middle of EXEC: abort with no write, flags cleared at once
      @(negedge clk);
      issue(0, 1, 1, 2, 0, 1'b0, 1'b0, dummy); // ADD r1,r1,r2 (never completes)
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_rf_we", int'(rf_we), 0);
      check("midrst_instr_ready", int'(instr_ready), 1);
      check("midrst_flags", int'({flag_z, flag_c, flag_n}), 0);
      mz = 0; mc = 0; mn = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) check("rf_kept_after_reset", int'(rf[i]), regs[i]);

      // Random instructions with random gaps and held-valid back-to-back runs
      for (int k = 0; k < 80; k++) begin
         bit keep;
         keep = bit'($urandom_range(0, 1));
         issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)), keep, 1'b1, dummy);
         if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      instr_valid = 1'b0;
      drain();
      for (int i = 0; i < 4; i++) check("rf_final", int'(rf[i]), regs[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
